// File: rtl/flow_ctrl_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : flow_ctrl_mc_if                                            |
// | Brief   : Stall/redirect request and control-mask bundle for         |
// |           flow_ctrl_mc. Perf ports exist with FLOW_CTRL_PERF_CNT_EN. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface flow_ctrl_mc_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0] stall_req_i;
  logic               id_jump_flag_i;
  logic [XLEN-1:0]    id_jump_pc_i;
  logic               ex_branch_flag_i;
  logic [XLEN-1:0]    ex_jump_pc_i;
  logic               mem_exc_flag_i;
  logic [XLEN-1:0]    mem_exc_pc_i;
  logic [4:0]         fc_stall_o;
  logic [4:0]         fc_flush_o;
  logic               fc_jump_flag_o;
  logic [XLEN-1:0]    fc_jump_pc_o;
  logic               fc_redirect_pend_o;
`ifdef FLOW_CTRL_PERF_CNT_EN
  logic [NUM_SRC*32-1:0] perf_stall_cnt_o;
  logic [31:0]           perf_redirect_cnt_o;
`endif

  modport master (
    output stall_req_i, id_jump_flag_i, id_jump_pc_i,
    output ex_branch_flag_i, ex_jump_pc_i, mem_exc_flag_i, mem_exc_pc_i,
`ifdef FLOW_CTRL_PERF_CNT_EN
    input  perf_stall_cnt_o, perf_redirect_cnt_o,
`endif
    input  fc_stall_o, fc_flush_o, fc_jump_flag_o, fc_jump_pc_o, fc_redirect_pend_o
  );

  modport slave (
    input  stall_req_i, id_jump_flag_i, id_jump_pc_i,
    input  ex_branch_flag_i, ex_jump_pc_i, mem_exc_flag_i, mem_exc_pc_i,
`ifdef FLOW_CTRL_PERF_CNT_EN
    output perf_stall_cnt_o, perf_redirect_cnt_o,
`endif
    output fc_stall_o, fc_flush_o, fc_jump_flag_o, fc_jump_pc_o, fc_redirect_pend_o
  );
endinterface
`default_nettype wire

// File: rtl/flow_ctrl_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : flow_ctrl_mc                                               |
// | Brief   : 5-stage pipeline flow controller: stall/flush masks, PC    |
// |           redirect, pending-redirect hold. Optional perf counters    |
// |           under macro FLOW_CTRL_PERF_CNT_EN.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flow_ctrl_mc #(
  parameter int                   XLEN      = 32,
  parameter int                   NUM_SRC   = 3,
  parameter logic [3*NUM_SRC-1:0] SRC_STAGE = {3'd3, 3'd2, 3'd0}
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  flow_ctrl_mc_if.slave fc
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [2:0] c_stg_jump   = 3'd1;
  localparam logic [2:0] c_stg_branch = 3'd2;
  localparam logic [2:0] c_stg_exc    = 3'd3;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic [2:0]      r_pend_src;
  logic [2:0]      w_pend_src_nxt;

  logic            w_stall_any;
  logic [2:0]      w_stall_max;
  logic [4:0]      w_stall_base;
  logic [4:0]      w_bubble;

  logic            w_red_valid;
  logic            w_red_ok;
  logic [2:0]      w_red_stage;
  logic [XLEN-1:0] w_red_tgt;
  logic [4:0]      w_red_flush;

  logic            w_take;
  logic            w_jump_flag;
  logic [XLEN-1:0] w_jump_pc;
  logic [4:0]      w_flush;
  logic            w_pend_out;

  // Deepest stalled stage across all asserted requesters.
  always_comb begin
    w_stall_any = 1'b0;
    w_stall_max = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fc.stall_req_i[i]) begin
        w_stall_any = 1'b1;
        if (SRC_STAGE[3*i +: 3] > w_stall_max) begin
          w_stall_max = SRC_STAGE[3*i +: 3];
        end
      end
    end
  end

  always_comb begin
    w_stall_base = '0;
    w_bubble     = '0;
    for (int k = 0; k < 5; k++) begin
      w_stall_base[k] = w_stall_any && (3'(k) <= w_stall_max);
      if (k > 0) begin
        w_bubble[k] = w_stall_any && (({1'b0, w_stall_max} + 4'd1) == 4'(k));
      end
    end
  end

  always_comb begin
    w_red_valid = 1'b1;
    w_red_stage = '0;
    w_red_tgt   = '0;
    if (fc.mem_exc_flag_i) begin
      w_red_stage = c_stg_exc;
      w_red_tgt   = fc.mem_exc_pc_i;
    end else if (fc.ex_branch_flag_i) begin
      w_red_stage = c_stg_branch;
      w_red_tgt   = fc.ex_jump_pc_i;
    end else if (fc.id_jump_flag_i) begin
      w_red_stage = c_stg_jump;
      w_red_tgt   = fc.id_jump_pc_i;
    end else begin
      w_red_valid = 1'b0;
    end
  end

  // A stalled source instruction will re-assert its redirect later.
  assign w_red_ok = w_red_valid && !(w_stall_any && (w_stall_max >= w_red_stage));

  always_comb begin
    w_red_flush = '0;
    for (int k = 1; k < 5; k++) begin
      w_red_flush[k] = (3'(k) <= w_red_stage) ||
                       ((w_red_stage == c_stg_exc) && (4'(k) == ({1'b0, w_red_stage} + 4'd1)));
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_pc_nxt  = r_pend_pc;
    w_pend_src_nxt = r_pend_src;
    w_take         = 1'b0;
    w_jump_flag    = 1'b0;
    w_jump_pc      = '0;
    w_flush        = w_bubble;
    w_pend_out     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_red_ok) begin
          w_take      = 1'b1;
          w_flush     = w_flush | w_red_flush;
          w_jump_flag = 1'b1;
          w_jump_pc   = w_red_tgt;
          // PC is held whenever any stall is active, so park the target.
          if (w_stall_any) begin
            w_pend_pc_nxt  = w_red_tgt;
            w_pend_src_nxt = w_red_stage;
            w_state_nxt    = ST_PEND;
            w_pend_out     = 1'b1;
          end
        end
      end
      ST_PEND: begin
        w_pend_out  = 1'b1;
        w_jump_flag = 1'b1;
        w_flush[1]  = 1'b1;
        if (w_red_ok && (w_red_stage > r_pend_src)) begin
          w_take         = 1'b1;
          w_flush        = w_flush | w_red_flush;
          w_pend_pc_nxt  = w_red_tgt;
          w_pend_src_nxt = w_red_stage;
        end
        w_jump_pc = w_pend_pc_nxt;
        if (!w_stall_any) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pend_pc  <= '0;
      r_pend_src <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_pend_src <= w_pend_src_nxt;
    end
  end

  assign fc.fc_stall_o         = w_stall_base & ~w_flush;
  assign fc.fc_flush_o         = {w_flush[4:1], 1'b0};
  assign fc.fc_jump_flag_o     = w_jump_flag;
  assign fc.fc_jump_pc_o       = w_jump_flag ? w_jump_pc : '0;
  assign fc.fc_redirect_pend_o = w_pend_out;

`ifdef FLOW_CTRL_PERF_CNT_EN
  logic [NUM_SRC*32-1:0] r_perf_stall_cnt;
  logic [31:0]           r_perf_redirect_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt    <= '0;
      r_perf_redirect_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (fc.stall_req_i[i]) begin
          r_perf_stall_cnt[32*i +: 32] <= r_perf_stall_cnt[32*i +: 32] + 32'd1;
        end
      end
      if (w_take) begin
        r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
      end
    end
  end

  assign fc.perf_stall_cnt_o    = r_perf_stall_cnt;
  assign fc.perf_redirect_cnt_o = r_perf_redirect_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_flow_ctrl_mc                                            |
// | Brief   : Scoreboard bench for flow_ctrl_mc (FLOW_CTRL_PERF_CNT_EN   |
// |           adds counter checks).                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_flow_ctrl_mc;

  typedef struct packed {
    logic [2:0]  sr;
    logic        jf;
    logic [31:0] jpc;
    logic        bf;
    logic [31:0] bpc;
    logic        ef;
    logic [31:0] epc;
  } stim_t;

  typedef struct packed {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        jf;
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb [$];

  flow_ctrl_mc_if #(.XLEN(32), .NUM_SRC(3)) fc_if ();

  flow_ctrl_mc #(.XLEN(32), .NUM_SRC(3), .SRC_STAGE({3'd3, 3'd2, 3'd0})) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc    (fc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(logic [2:0] sr, logic jf, logic [31:0] jpc, logic bf,
                               logic [31:0] bpc, logic ef, logic [31:0] epc);
    mk = '{sr: sr, jf: jf, jpc: jpc, bf: bf, bpc: bpc, ef: ef, epc: epc};
  endfunction

  function automatic exp_t ex(logic [4:0] st, logic [4:0] fl, logic jf, logic [31:0] pc, logic pend);
    ex = '{stall: st, flush: fl, jf: jf, pc: pc, pend: pend};
  endfunction

  function automatic exp_t observe();
    observe = '{stall: fc_if.fc_stall_o, flush: fc_if.fc_flush_o, jf: fc_if.fc_jump_flag_o,
                pc: fc_if.fc_jump_pc_o, pend: fc_if.fc_redirect_pend_o};
  endfunction

  task automatic drive(input stim_t s);
    fc_if.stall_req_i      = s.sr;
    fc_if.id_jump_flag_i   = s.jf;
    fc_if.id_jump_pc_i     = s.jpc;
    fc_if.ex_branch_flag_i = s.bf;
    fc_if.ex_jump_pc_i     = s.bpc;
    fc_if.mem_exc_flag_i   = s.ef;
    fc_if.mem_exc_pc_i     = s.epc;
  endtask

  task automatic test_reset();
    exp_t got, want;
    rst_n = 1'b0;
    drive(mk(3'b000, 0, 0, 0, 0, 0, 0));
    sb.push_back(ex(5'b0, 5'b0, 0, 0, 0));
    @(negedge clk);
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", got, want);
    end
`ifdef FLOW_CTRL_PERF_CNT_EN
    vectors++;
    if ({fc_if.perf_stall_cnt_o, fc_if.perf_redirect_cnt_o} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_perf: got %h want 0", {fc_if.perf_stall_cnt_o, fc_if.perf_redirect_cnt_o});
    end
`endif
    rst_n = 1'b1;
  endtask

`ifdef FLOW_CTRL_PERF_CNT_EN
  task automatic test_perf();
    stim_t st [4];
    exp_t  xp [4];
    exp_t  got, want;
    st = '{mk(3'b011, 0, 0, 0, 0, 0, 0), mk(3'b011, 0, 0, 0, 0, 0, 0),
           mk(3'b000, 0, 0, 1, 32'h40, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b00111, 5'b01000, 0, 0, 0), ex(5'b00111, 5'b01000, 0, 0, 0),
           ex(5'b00000, 5'b00110, 1, 32'h40, 0), ex(5'b0, 5'b0, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL perf_step%0d: got %h want %h", i, got, want);
      end
    end
    vectors++;
    if ({fc_if.perf_stall_cnt_o, fc_if.perf_redirect_cnt_o} !== {32'd0, 32'd2, 32'd2, 32'd1}) begin
      miscompares++;
      $display("FAIL perf_counts: got %h want %h", {fc_if.perf_stall_cnt_o, fc_if.perf_redirect_cnt_o},
               {32'd0, 32'd2, 32'd2, 32'd1});
    end
  endtask
`endif

  task automatic test_stall();
    stim_t st [5];
    exp_t  xp [5];
    exp_t  got, want;
    st = '{mk(3'b010, 0, 0, 0, 0, 0, 0), mk(3'b001, 0, 0, 0, 0, 0, 0), mk(3'b100, 0, 0, 0, 0, 0, 0),
           mk(3'b111, 0, 0, 0, 0, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b00111, 5'b01000, 0, 0, 0), ex(5'b00001, 5'b00010, 0, 0, 0),
           ex(5'b01111, 5'b10000, 0, 0, 0), ex(5'b01111, 5'b10000, 0, 0, 0), ex(5'b0, 5'b0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stall_step%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t st [5];
    exp_t  xp [5];
    exp_t  got, want;
    st = '{mk(3'b000, 0, 0, 1, 32'h100, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0),
           mk(3'b000, 1, 32'h44, 0, 0, 0, 0), mk(3'b000, 0, 0, 0, 0, 1, 32'h80),
           mk(3'b000, 1, 32'h11, 1, 32'h22, 1, 32'h33)};
    xp = '{ex(5'b0, 5'b00110, 1, 32'h100, 0), ex(5'b0, 5'b0, 0, 0, 0),
           ex(5'b0, 5'b00010, 1, 32'h44, 0), ex(5'b0, 5'b11110, 1, 32'h80, 0),
           ex(5'b0, 5'b11110, 1, 32'h33, 0)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL redirect_step%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_pend();
    stim_t st [5];
    exp_t  xp [5];
    exp_t  got, want;
    st = '{mk(3'b001, 1, 32'h200, 0, 0, 0, 0), mk(3'b001, 0, 0, 0, 0, 0, 0),
           mk(3'b001, 0, 0, 0, 0, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b00001, 5'b00010, 1, 32'h200, 1), ex(5'b00001, 5'b00010, 1, 32'h200, 1),
           ex(5'b00001, 5'b00010, 1, 32'h200, 1), ex(5'b00000, 5'b00010, 1, 32'h200, 1),
           ex(5'b0, 5'b0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL pend_cycle%0d: got %h want %h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_pend_overwrite();
    stim_t st [5];
    exp_t  xp [5];
    exp_t  got, want;
    st = '{mk(3'b001, 1, 32'h200, 0, 0, 0, 0), mk(3'b001, 0, 0, 0, 0, 1, 32'h80),
           mk(3'b001, 1, 32'h300, 0, 0, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0), mk(3'b000, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b00001, 5'b00010, 1, 32'h200, 1), ex(5'b00001, 5'b11110, 1, 32'h80, 1),
           ex(5'b00001, 5'b00010, 1, 32'h80, 1), ex(5'b00000, 5'b00010, 1, 32'h80, 1),
           ex(5'b0, 5'b0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL overwrite_cycle%0d: got %h want %h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_suppress();
    stim_t st [5];
    exp_t  xp [5];
    exp_t  got, want;
    st = '{mk(3'b100, 0, 0, 1, 32'h100, 0, 0), mk(3'b010, 0, 0, 1, 32'h100, 0, 0),
           mk(3'b010, 1, 32'h44, 0, 0, 0, 0), mk(3'b100, 0, 0, 0, 0, 1, 32'h80),
           mk(3'b000, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b01111, 5'b10000, 0, 0, 0), ex(5'b00111, 5'b01000, 0, 0, 0),
           ex(5'b00111, 5'b01000, 0, 0, 0), ex(5'b01111, 5'b10000, 0, 0, 0), ex(5'b0, 5'b0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL suppress_step%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st [5];
    exp_t  xp [5];
    exp_t  got, want;
    st = '{mk(3'b000, 1, 32'h10, 0, 0, 0, 0), mk(3'b000, 0, 0, 1, 32'h20, 0, 0),
           mk(3'b000, 0, 0, 0, 0, 1, 32'h30), mk(3'b000, 1, 32'h11, 1, 32'h24, 0, 0),
           mk(3'b000, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b0, 5'b00010, 1, 32'h10, 0), ex(5'b0, 5'b00110, 1, 32'h20, 0),
           ex(5'b0, 5'b11110, 1, 32'h30, 0), ex(5'b0, 5'b00110, 1, 32'h24, 0), ex(5'b0, 5'b0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b_step%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st [2];
    exp_t  xp [2];
    exp_t  got, want;
    st = '{mk(3'b001, 1, 32'h200, 0, 0, 0, 0), mk(3'b001, 0, 0, 0, 0, 0, 0)};
    xp = '{ex(5'b00001, 5'b00010, 1, 32'h200, 1), ex(5'b00001, 5'b00010, 1, 32'h200, 1)};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL areset_pre%0d: got %h want %h", i, got, want);
      end
    end
    #2;
    rst_n = 1'b0;
    sb.push_back(ex(5'b00001, 5'b00010, 0, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL areset_mid_pend: got %h want %h", got, want);
    end
`ifdef FLOW_CTRL_PERF_CNT_EN
    vectors++;
    if ({fc_if.perf_stall_cnt_o, fc_if.perf_redirect_cnt_o} !== 128'd0) begin
      miscompares++;
      $display("FAIL areset_perf: got %h want 0", {fc_if.perf_stall_cnt_o, fc_if.perf_redirect_cnt_o});
    end
`endif
    @(negedge clk);
    drive(mk(3'b000, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    sb.push_back(ex(5'b0, 5'b0, 0, 0, 0));
    @(negedge clk);
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL areset_after: got %h want %h", got, want);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
`ifdef FLOW_CTRL_PERF_CNT_EN
    test_perf();
`endif
    test_stall();
    test_redirect();
    test_pend();
    test_pend_overwrite();
    test_suppress();
    test_back_to_back();
    test_async_reset();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
